// File: rtl/l2_pkg.sv
// Shared L2 types: line format, refill FSM states and the
// memory read-channel request/response bundles.
package l2_pkg;

  localparam int LINE_B   = 32;
  localparam int LINE_W   = LINE_B * 8;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 64;
  localparam int TAG_W    = ADDR_W - OFFSET_W;

  typedef logic [7:0][31:0] line_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_AR,
    S_R,
    S_RESP
  } l2_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } mem_ar_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       last;
  } mem_r_t;

  function automatic logic [ADDR_W-1:0] line_align(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/l2_line_buf.sv
// Single-entry last-line buffer: tag/valid/data with hit compare.
// Ports: lookup tag -> hit/rd_data; wr_en/inv/flush update the entry.
module l2_line_buf
  import l2_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output line_t            rd_data,
  input  logic             wr_en,
  input  logic             inv,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_data
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  line_t            data_q;

  assign hit     = valid_q && (tag_q == lookup_tag);
  assign rd_data = data_q;

  // Invalidation wins over a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (flush || inv) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
      tag_q   <= wr_tag;
      data_q  <= wr_data;
    end
  end

endmodule

// File: rtl/l2_iline_server.sv
// Icache line-refill responder: serves hits from a last-line buffer,
// otherwise fetches the 32 B line as an incrementing memory burst.
module l2_iline_server
  import l2_pkg::*;
#(
  parameter int              BUS_W = 64,
  parameter int              ID_W  = 4,
  parameter logic [ID_W-1:0] ARID  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_l2_rreq,
  input  logic [63:0]       icache_l2_raddr,
  output logic              l2_icache_rask,
  output line_t             l2_icache_rdata,
  output logic              l2_icache_rerr,
  input  logic              flush,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [63:0]       mem_araddr,
  output logic [7:0]        mem_arlen,
  output logic [ID_W-1:0]   mem_arid,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  l2_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_nxt;
  logic              err_q;
  logic              err_nxt;
  logic              flush_pend;
  logic              beat;
  logic              last_beat;
  logic              buf_hit;
  line_t             buf_data;
  logic              buf_wr;
  logic              buf_inv;
  mem_ar_t           ar_req;
  mem_r_t            r_rsp;
  logic              unused_ok;

  assign unused_ok = &{1'b0, icache_l2_raddr[OFFSET_W-1:0]};

  assign ar_req.addr = line_align(icache_l2_raddr);
  assign ar_req.len  = 8'(BEATS - 1);
  assign r_rsp.resp  = mem_rresp;
  assign r_rsp.last  = mem_rlast;

  assign beat      = mem_rvalid && mem_rready;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  // Merge the current beat so RESP can present the full line at once.
  always_comb begin
    line_nxt = line_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat && cnt == CNT_W'(b)) begin
        line_nxt[b*BUS_W +: BUS_W] = mem_rdata;
      end
    end
  end

  // rlast is only cross-checked; the beat counter ends the burst.
  always_comb begin
    err_nxt = err_q;
    if (beat) begin
      if (r_rsp.resp != 2'b00) err_nxt = 1'b1;
      if (r_rsp.last != last_beat) err_nxt = 1'b1;
    end
  end

  assign buf_wr  = (state == S_RESP) && !err_q && !flush_pend;
  assign buf_inv = (state == S_RESP) && err_q;

  l2_line_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .lookup_tag (icache_l2_raddr[63:OFFSET_W]),
    .hit        (buf_hit),
    .rd_data    (buf_data),
    .wr_en      (buf_wr),
    .inv        (buf_inv),
    .wr_tag     (tag_q),
    .wr_data    (line_t'(line_q))
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      tag_q           <= '0;
      line_q          <= '0;
      err_q           <= 1'b0;
      flush_pend      <= 1'b0;
      l2_icache_rask  <= 1'b0;
      l2_icache_rdata <= '0;
      l2_icache_rerr  <= 1'b0;
      mem_arvalid     <= 1'b0;
      mem_araddr      <= '0;
      mem_arlen       <= '0;
      mem_arid        <= '0;
      mem_rready      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          flush_pend <= 1'b0;
          if (icache_l2_rreq) begin
            tag_q <= icache_l2_raddr[63:OFFSET_W];
            if (buf_hit && !flush) begin
              state           <= S_HIT;
              l2_icache_rask  <= 1'b1;
              l2_icache_rdata <= buf_data;
              l2_icache_rerr  <= 1'b0;
            end else begin
              state       <= S_AR;
              err_q       <= 1'b0;
              mem_arvalid <= 1'b1;
              mem_araddr  <= ar_req.addr;
              mem_arlen   <= ar_req.len;
              mem_arid    <= ARID;
            end
          end
        end
        S_HIT: begin
          l2_icache_rask <= 1'b0;
          state          <= S_IDLE;
        end
        S_AR: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
            cnt         <= '0;
            state       <= S_R;
          end
        end
        S_R: begin
          if (flush) flush_pend <= 1'b1;
          if (beat) begin
            line_q <= line_nxt;
            err_q  <= err_nxt;
            if (last_beat) begin
              mem_rready      <= 1'b0;
              l2_icache_rask  <= 1'b1;
              l2_icache_rdata <= line_t'(line_nxt);
              l2_icache_rerr  <= err_nxt;
              state           <= S_RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_RESP: begin
          l2_icache_rask <= 1'b0;
          l2_icache_rerr <= 1'b0;
          flush_pend     <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_one_req: assert property (
    @(posedge clk) disable iff (rst)
    icache_l2_rreq |-> state == S_IDLE
  );
`endif

endmodule

// File: tb/tb_l2_iline_server.sv
// Directed bench for l2_iline_server: vector table of requests
// against a beat-level memory model, plus a mid-burst reset sequence.
module tb_l2_iline_server;
  import l2_pkg::*;

  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rreq = 1'b0;
  logic [63:0] raddr = '0;
  logic        rask;
  line_t       rdata;
  logic        rerr;
  logic        flush = 1'b0;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [63:0] mrdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  l2_iline_server dut (
    .clk             (clk),
    .rst             (rst),
    .icache_l2_rreq  (rreq),
    .icache_l2_raddr (raddr),
    .l2_icache_rask  (rask),
    .l2_icache_rdata (rdata),
    .l2_icache_rerr  (rerr),
    .flush           (flush),
    .mem_arvalid     (arvalid),
    .mem_arready     (arready),
    .mem_araddr      (araddr),
    .mem_arlen       (arlen),
    .mem_arid        (arid),
    .mem_rvalid      (rvalid),
    .mem_rready      (rready),
    .mem_rdata       (mrdata),
    .mem_rresp       (rresp),
    .mem_rlast       (rlast)
  );

  typedef struct {
    logic [63:0] addr;
    bit          fl_req;
    int          s;
    int          g;
    int          err_b;
    int          fl_b;
    logic [63:0] salt;
    bit          exp_ar;
    logic [63:0] exp_araddr;
    int          exp_lat;
    bit          exp_err;
    logic [63:0] exp_salt;
  } vec_t;

  vec_t vt[12];

  function automatic logic [63:0] beat_val(int k, logic [63:0] salt);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = 32'(32'h1111_1111 * (2 * k));
    hi = 32'(32'h1111_1111 * (2 * k + 1));
    return {hi, lo} ^ salt;
  endfunction

  function automatic line_t exp_line(logic [63:0] salt);
    line_t l;
    for (int w = 0; w < 8; w++) begin
      l[w] = 32'(32'h1111_1111 * w) ^
             ((w % 2 == 1) ? salt[63:32] : salt[31:0]);
    end
    return l;
  endfunction

  task automatic chk(input int id, input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %0h want %0h", id, nm, act, exp);
    end
  endtask

  task automatic run_req(
    input  logic [63:0] addr,
    input  bit          fl_req,
    input  int          s,
    input  int          g,
    input  int          err_b,
    input  int          fl_b,
    input  int          rst_b,
    input  logic [63:0] salt,
    output bit          saw_ar,
    output bit          ar_stable,
    output logic [63:0] ar_a,
    output logic [7:0]  ar_l,
    output int          nrask,
    output int          lat,
    output logic        got_err,
    output line_t       line,
    output bit          rst_ok
  );
    int  sl;
    int  gl;
    int  sent;
    int  stop;
    bit  rst_hit;
    saw_ar = 0; ar_stable = 1; ar_a = '0; ar_l = '0;
    nrask = 0; lat = -1; got_err = 1'b0; line = '0;
    rst_ok = 1; sl = s; gl = g; sent = 0; stop = -1;
    rst_hit = 0;
    rreq = 1'b1; raddr = addr; flush = fl_req;
    @(posedge clk); #1;
    rreq = 1'b0; raddr = '0; flush = 1'b0;
    for (int t = 1; t < 80; t++) begin
      if (rst_hit) begin
        rst = 1'b0;
        if (arvalid || rready || rask || rerr ||
            araddr != 0 || arlen != 0 || arid != 0 ||
            rdata != '0) rst_ok = 0;
        rst_hit = 0; sent = BEATS; sl = 1000; stop = t + 5;
      end
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      rresp = 2'b00; flush = 1'b0;
      if (arvalid) begin
        if (!saw_ar) begin
          ar_a = araddr; ar_l = arlen;
        end else if (araddr != ar_a || arlen != ar_l) begin
          ar_stable = 0;
        end
        saw_ar = 1;
        if (sl > 0) sl--;
        else arready = 1'b1;
      end
      if (rready && sent < BEATS) begin
        if (gl > 0) begin
          gl--;
        end else begin
          rvalid = 1'b1;
          mrdata = beat_val(sent, salt);
          rlast  = (sent == BEATS - 1);
          rresp  = (sent == err_b) ? 2'd2 : 2'd0;
          if (sent == fl_b) flush = 1'b1;
          if (sent == rst_b) begin
            rst = 1'b1; rst_hit = 1;
          end
          sent++;
          gl = g;
        end
      end
      if (rask) begin
        nrask++;
        if (lat < 0) begin
          lat = t; got_err = rerr; line = rdata; stop = t + 3;
        end
      end
      if (t == stop) break;
      @(posedge clk); #1;
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rresp = 2'b00; flush = 1'b0; mrdata = '0;
  endtask

  task automatic apply_vec(input int id, input vec_t v);
    bit          saw_ar;
    bit          ar_st;
    logic [63:0] ar_a;
    logic [7:0]  ar_l;
    int          nrask;
    int          lat;
    logic        e;
    line_t       l;
    bit          rok;
    run_req(v.addr, v.fl_req, v.s, v.g, v.err_b, v.fl_b, -1,
            v.salt, saw_ar, ar_st, ar_a, ar_l, nrask, lat,
            e, l, rok);
    chk(id, "ar_seen", 256'(saw_ar), 256'(v.exp_ar));
    if (v.exp_ar) begin
      chk(id, "araddr", 256'(ar_a), 256'(v.exp_araddr));
      chk(id, "arlen", 256'(ar_l), 256'(BEATS - 1));
      chk(id, "ar_stable", 256'(ar_st), 256'(1));
    end
    chk(id, "rask_count", 256'(nrask), 256'(1));
    chk(id, "latency", 256'(lat), 256'(v.exp_lat));
    chk(id, "rerr", 256'(e), 256'(v.exp_err));
    chk(id, "line", 256'(l), 256'(exp_line(v.exp_salt)));
  endtask

  initial begin
    bit          saw_ar;
    bit          ar_st;
    logic [63:0] ar_a;
    logic [7:0]  ar_l;
    int          nrask;
    int          lat;
    logic        e;
    line_t       l;
    bit          rok;
    vec_t        hv;

    //      addr  flq s g eb fb salt  ar araddr lat err exp_salt
    vt[0]  = '{64'h8000_0014, 0, 0, 0, -1, -1, 64'h0,
               1, 64'h8000_0000, 6, 0, 64'h0};
    vt[1]  = '{64'h8000_0008, 0, 0, 0, -1, -1, 64'hdead_beef,
               0, 64'h0, 1, 0, 64'h0};
    vt[2]  = '{64'h9000_0040, 0, 3, 2, -1, -1, 64'h0a0a_0a0a_a0a0_a0a0,
               1, 64'h9000_0040, 17, 0, 64'h0a0a_0a0a_a0a0_a0a0};
    vt[3]  = '{64'h9000_005c, 0, 0, 0, -1, -1, 64'h5,
               0, 64'h0, 1, 0, 64'h0a0a_0a0a_a0a0_a0a0};
    vt[4]  = '{64'ha000_0000, 0, 0, 0, 2, -1, 64'hb0b0,
               1, 64'ha000_0000, 6, 1, 64'hb0b0};
    vt[5]  = '{64'ha000_0010, 0, 0, 0, -1, -1, 64'hc0c0_0000,
               1, 64'ha000_0000, 6, 0, 64'hc0c0_0000};
    vt[6]  = '{64'ha000_0004, 0, 0, 0, -1, -1, 64'h1,
               0, 64'h0, 1, 0, 64'hc0c0_0000};
    vt[7]  = '{64'hb000_0020, 0, 0, 0, -1, 1, 64'hd0d0_d0d0_0000_0000,
               1, 64'hb000_0020, 6, 0, 64'hd0d0_d0d0_0000_0000};
    vt[8]  = '{64'hb000_0020, 0, 0, 0, -1, -1, 64'he0e0,
               1, 64'hb000_0020, 6, 0, 64'he0e0};
    vt[9]  = '{64'hb000_003f, 1, 0, 0, -1, -1, 64'hf0f0_f0f0_f0f0,
               1, 64'hb000_0020, 6, 0, 64'hf0f0_f0f0_f0f0};
    vt[10] = '{64'hb000_0030, 0, 0, 0, -1, -1, 64'h2,
               0, 64'h0, 1, 0, 64'hf0f0_f0f0_f0f0};
    vt[11] = '{64'h8000_0000, 0, 0, 0, -1, -1, 64'h1234_5678_9abc_def0,
               1, 64'h8000_0000, 6, 0, 64'h1234_5678_9abc_def0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk(0, "rst_rask", 256'(rask), 256'(0));
    chk(0, "rst_rerr", 256'(rerr), 256'(0));
    chk(0, "rst_rdata", 256'(rdata), 256'(0));
    chk(0, "rst_arvalid", 256'(arvalid), 256'(0));
    chk(0, "rst_araddr", 256'(araddr), 256'(0));
    chk(0, "rst_arlen", 256'(arlen), 256'(0));
    chk(0, "rst_rready", 256'(rready), 256'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) apply_vec(i, vt[i]);

    // Reset on beat 2 abandons the burst; buffer must be invalid after.
    run_req(64'hc000_0000, 0, 0, 0, -1, -1, 2, 64'h77,
            saw_ar, ar_st, ar_a, ar_l, nrask, lat, e, l, rok);
    chk(100, "rst_ar_seen", 256'(saw_ar), 256'(1));
    chk(100, "rst_outputs_zero", 256'(rok), 256'(1));
    chk(100, "rst_no_rask", 256'(nrask), 256'(0));

    hv = '{64'h8000_0010, 0, 0, 0, -1, -1, 64'h99,
           1, 64'h8000_0000, 6, 0, 64'h99};
    apply_vec(101, hv);
    hv = '{64'h8000_001c, 0, 0, 0, -1, -1, 64'h3,
           0, 64'h0, 1, 0, 64'h99};
    apply_vec(102, hv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
